// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
//
// Shares one ALU between NUM_REQ requesters. Each cycle that the output slot
// is free, a round-robin arbiter picks one valid requester. Its operation is
// computed and registered into a single result slot, tagged with the
// requester index. Downstream drains the slot over valid/ready.
//
// Optional build macro: ALU_RR_SCHED_PERF_CNT_EN adds a 32-bit grant counter
// output (grant_cnt_o).
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-high
//   req_a_i      operand A per requester, packed DATA_IN_WIDTH each
//   req_b_i      operand B per requester, packed DATA_IN_WIDTH each
//   req_op_i     3-bit opcode per requester, packed
//   req_valid_i  request valid per requester
//   req_ready_o  grant per requester (one-hot or zero)
//   res_o        registered result
//   res_carry_o  carry / borrow / shifted-out bit of the result
//   res_id_o     index of the requester that produced res_o
//   res_valid_o  result slot holds valid data
//   res_ready_i  downstream accepts the result
//   grant_cnt_o  (macro only) number of grants since reset, wraps at 2^32
//
// Opcodes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 pass A,
//          110 shl A, 111 logical shr A.
// ---------------------------------------------------------------------------

// Per-requester operand gate: forwards the lane's operands only when the
// lane holds the grant, so the shared ALU input is a plain OR of all lanes.
module alu_rr_scheduler_lane #(
    parameter int DATA_IN_WIDTH = 8
) (
    input  logic                     sel,
    input  logic [DATA_IN_WIDTH-1:0] a,
    input  logic [DATA_IN_WIDTH-1:0] b,
    input  logic [2:0]               op,
    output logic [DATA_IN_WIDTH-1:0] a_g,
    output logic [DATA_IN_WIDTH-1:0] b_g,
    output logic [2:0]               op_g
);
    assign a_g  = sel ? a  : '0;
    assign b_g  = sel ? b  : '0;
    assign op_g = sel ? op : '0;
endmodule

module alu_rr_scheduler #(
    parameter  int NUM_REQ       = 4,
    parameter  int DATA_IN_WIDTH = 8,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ*DATA_IN_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_IN_WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ*3-1:0]             req_op_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic [DATA_IN_WIDTH-1:0]         res_o,
    output logic                             res_carry_o,
    output logic [ID_W-1:0]                  res_id_o,
    output logic                             res_valid_o,
    input  logic                             res_ready_i
`ifdef ALU_RR_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]                      grant_cnt_o
`endif
);
    localparam int W = DATA_IN_WIDTH;

    typedef struct packed {
        logic [W-1:0]    data;
        logic            carry;
        logic [ID_W-1:0] id;
    } res_t;

    res_t            res_q;
    logic [ID_W-1:0] rr_ptr;

    // ---------------- arbitration ----------------
    // Returns {found, winner}: first valid bit at or above ptr, with wrap.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    ptr);
        logic            found;
        logic [ID_W-1:0] w;
        logic [ID_W-1:0] idx;
        found = 1'b0;
        w     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && v[idx]) begin
                found = 1'b1;
                w     = idx;
            end
        end
        return {found, w};
    endfunction

    logic                slot_free;
    logic                pick_found;
    logic [ID_W-1:0]     pick_w;
    logic [NUM_REQ-1:0]  grant_vec;
    logic                grant;
    logic [ID_W-1:0]     ptr_nxt;

    // A draining result frees the slot in the same cycle (pass-through).
    assign slot_free              = !res_valid_o || res_ready_i;
    assign {pick_found, pick_w}   = rr_pick(req_valid_i, rr_ptr);

    always_comb begin
        grant_vec = '0;
        if (!rst_i && slot_free && pick_found)
            grant_vec[pick_w] = 1'b1;
    end

    assign grant       = |grant_vec;
    assign req_ready_o = grant_vec;
    assign ptr_nxt     = (pick_w == ID_W'(NUM_REQ - 1)) ? '0 : pick_w + ID_W'(1);

    // ---------------- operand select ----------------
    logic [NUM_REQ-1:0][W-1:0] a_g;
    logic [NUM_REQ-1:0][W-1:0] b_g;
    logic [NUM_REQ-1:0][2:0]   op_g;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        alu_rr_scheduler_lane #(.DATA_IN_WIDTH(W)) u_lane (
            .sel  (grant_vec[k]),
            .a    (req_a_i[k*W +: W]),
            .b    (req_b_i[k*W +: W]),
            .op   (req_op_i[k*3 +: 3]),
            .a_g  (a_g[k]),
            .b_g  (b_g[k]),
            .op_g (op_g[k])
        );
    end

    logic [W-1:0] a_sel;
    logic [W-1:0] b_sel;
    logic [2:0]   op_sel;

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            a_sel  = a_sel  | a_g[k];
            b_sel  = b_sel  | b_g[k];
            op_sel = op_sel | op_g[k];
        end
    end

    // ---------------- ALU ----------------
    logic [W-1:0] alu_res;
    logic         alu_carry;
    logic [W:0]   ext;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        ext       = '0;
        case (op_sel)
            3'b000: begin
                ext       = {1'b0, a_sel} + {1'b0, b_sel};
                alu_res   = ext[W-1:0];
                alu_carry = ext[W];
            end
            3'b001: begin
                // Top bit of the widened difference is the borrow (A < B).
                ext       = {1'b0, a_sel} - {1'b0, b_sel};
                alu_res   = ext[W-1:0];
                alu_carry = ext[W];
            end
            3'b010: alu_res = a_sel & b_sel;
            3'b011: alu_res = a_sel | b_sel;
            3'b100: alu_res = a_sel ^ b_sel;
            3'b101: alu_res = a_sel;
            3'b110: begin
                alu_res   = {a_sel[W-2:0], 1'b0};
                alu_carry = a_sel[W-1];
            end
            default: begin
                alu_res   = {1'b0, a_sel[W-1:1]};
                alu_carry = a_sel[0];
            end
        endcase
    end

    // ---------------- result slot ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q       <= '0;
            res_valid_o <= 1'b0;
            rr_ptr      <= '0;
        end else if (grant) begin
            res_q       <= '{data: alu_res, carry: alu_carry, id: pick_w};
            res_valid_o <= 1'b1;
            rr_ptr      <= ptr_nxt;
        end else if (res_ready_i) begin
            res_valid_o <= 1'b0;
        end
    end

    assign res_o       = res_q.data;
    assign res_carry_o = res_q.carry;
    assign res_id_o    = res_q.id;

`ifdef ALU_RR_SCHED_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            grant_cnt_o <= '0;
        else if (grant)
            grant_cnt_o <= grant_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
module tb_alu_rr_scheduler;
    logic        clk;
    logic        rst;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [11:0] req_op;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  res;
    logic        res_carry;
    logic [1:0]  res_id;
    logic        res_valid;
    logic        res_ready;
`ifdef ALU_RR_SCHED_PERF_CNT_EN
    logic [31:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    alu_rr_scheduler #(.NUM_REQ(4), .DATA_IN_WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_op_i    (req_op),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .res_o       (res),
        .res_carry_o (res_carry),
        .res_id_o    (res_id),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready)
`ifdef ALU_RR_SCHED_PERF_CNT_EN
        ,
        .grant_cnt_o (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op);
        req_a[k*8 +: 8]  = a;
        req_b[k*8 +: 8]  = b;
        req_op[k*3 +: 3] = op;
    endtask

    // Reference ALU written arithmetically: returns {carry, result}.
    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0: return 9'(ia + ib);
            3'd1: return {a < b, 8'((ia - ib + 256) % 256)};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, a};
            3'd6: return {a >= 8'h80, 8'((ia * 2) % 256)};
            default: return {a[0], 8'(ia / 2)};
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (req_ready !== 4'b0000 || res_valid !== 1'b0 || res !== 8'h00 ||
                res_carry !== 1'b0 || res_id !== 2'd0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d ready=%b valid=%b res=%h c=%b id=%0d exp ready=0000 valid=0 res=00 c=0 id=0",
                         i, req_ready, res_valid, res, res_carry, res_id);
            end
        end
`ifdef ALU_RR_SCHED_PERF_CNT_EN
        checks++;
        if (grant_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d exp=0", grant_cnt);
        end
`endif
        rst = 1'b0; #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant got=%b exp=0001", req_ready);
        end
        req_valid = 4'h0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        @(negedge clk);
        for (int k = 0; k < 4; k++) set_req(k, 8'(16 * k + 1), 8'h01, 3'b000);
        req_valid = 4'hF; res_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_rdy = 4'(1 << (c % 4));
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, exp_rdy);
            end
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_id !== 2'(c % 4) || res !== 8'(16 * (c % 4) + 2) ||
                res_carry !== 1'b0) begin
                errors++;
                $display("FAIL rr_result c=%0d valid=%b id=%0d res=%h c=%b exp valid=1 id=%0d res=%h c=0",
                         c, res_valid, res_id, res, res_carry, c % 4, 8'(16 * (c % 4) + 2));
            end
        end
        req_valid = 4'h0;
    endtask

    task automatic test_arith();
        logic [7:0] ta [11] = '{8'hF0, 8'h05, 8'h81, 8'hF0, 8'hA5, 8'hFF,
                                8'h3C, 8'h81, 8'h10, 8'h20, 8'h7F};
        logic [7:0] tb [11] = '{8'h20, 8'h07, 8'hFF, 8'h0F, 8'h5A, 8'h0F,
                                8'hFF, 8'hFF, 8'h20, 8'h10, 8'h01};
        logic [2:0] to [11] = '{3'd0, 3'd1, 3'd7, 3'd2, 3'd3, 3'd4,
                                3'd5, 3'd6, 3'd1, 3'd1, 3'd0};
        logic [7:0] tr [11] = '{8'h10, 8'hFE, 8'h40, 8'h00, 8'hFF, 8'hF0,
                                8'h3C, 8'h02, 8'hF0, 8'h10, 8'h80};
        logic       tc [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        @(negedge clk);
        res_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            set_req(2, ta[i], tb[i], to[i]);
            req_valid = 4'b0100;
            #1;
            checks++;
            if (req_ready !== 4'b0100) begin
                errors++;
                $display("FAIL arith_grant i=%0d got=%b exp=0100", i, req_ready);
            end
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res !== tr[i] || res_carry !== tc[i] || res_id !== 2'd2) begin
                errors++;
                $display("FAIL arith_result i=%0d valid=%b res=%h c=%b id=%0d exp valid=1 res=%h c=%b id=2",
                         i, res_valid, res, res_carry, res_id, tr[i], tc[i]);
            end
        end
        req_valid = 4'h0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        res_ready = 1'b1;
        set_req(0, 8'h01, 8'h01, 3'd0);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_setup got=%b exp=0001", req_ready);
        end
        @(negedge clk);
        set_req(1, 8'h11, 8'h22, 3'd0);
        set_req(3, 8'h44, 8'h04, 3'd1);
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_first got=%b exp=0010", req_ready);
        end
        @(negedge clk);
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (req_ready !== 4'b0000 || res_valid !== 1'b1 || res_id !== 2'd1 ||
                res !== 8'h33 || res_carry !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold i=%0d ready=%b valid=%b id=%0d res=%h c=%b exp ready=0000 valid=1 id=1 res=33 c=0",
                         i, req_ready, res_valid, res_id, res, res_carry);
            end
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000 || res_id !== 2'd1 || res !== 8'h33) begin
            errors++;
            $display("FAIL bp_release ready=%b id=%0d res=%h exp ready=1000 id=1 res=33",
                     req_ready, res_id, res);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd3 || res !== 8'h40 || res_carry !== 1'b0) begin
            errors++;
            $display("FAIL bp_next valid=%b id=%0d res=%h c=%b exp valid=1 id=3 res=40 c=0",
                     res_valid, res_id, res, res_carry);
        end
        req_valid = 4'h0;
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        res_ready = 1'b1;
        set_req(2, 8'h55, 8'h00, 3'd5);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL mrst_grant got=%b exp=0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'h0; res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res !== 8'h55) begin
            errors++;
            $display("FAIL mrst_held valid=%b res=%h exp valid=1 res=55", res_valid, res);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || res !== 8'h00 || res_id !== 2'd0) begin
            errors++;
            $display("FAIL mrst_cleared valid=%b res=%h id=%0d exp valid=0 res=00 id=0",
                     res_valid, res, res_id);
        end
`ifdef ALU_RR_SCHED_PERF_CNT_EN
        checks++;
        if (grant_cnt !== 32'd0) begin
            errors++;
            $display("FAIL mrst_cnt got=%0d exp=0", grant_cnt);
        end
`endif
        req_valid = 4'hF; res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mrst_ptr got=%b exp=0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'h0;
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd0 || res !== 8'h02) begin
            errors++;
            $display("FAIL mrst_after valid=%b id=%0d res=%h exp valid=1 id=0 res=02",
                     res_valid, res_id, res);
        end
    endtask

    task automatic test_soak();
        logic [7:0] sa [4];
        logic [7:0] sb [4];
        logic [2:0] so [4];
        logic [3:0] pend;
        logic [3:0] exp_gnt;
        logic       m_vld;
        logic [7:0] m_res;
        logic       m_c;
        logic [1:0] m_id;
        logic [8:0] r;
        int         m_ptr;
        int         w;
        int         kk;
        int         grants;
        int         cyc;
        @(negedge clk);
        rst = 1'b1; req_valid = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        pend = 4'h0; m_vld = 1'b0; m_res = 8'h00; m_c = 1'b0; m_id = 2'd0;
        m_ptr = 0; grants = 0; cyc = 0;
        while (grants < 1000 && cyc < 8000) begin
            for (int k = 0; k < 4; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1'b1;
                    sa[k] = 8'($urandom_range(0, 255));
                    sb[k] = 8'($urandom_range(0, 255));
                    so[k] = 3'($urandom_range(0, 7));
                end
                set_req(k, sa[k], sb[k], so[k]);
            end
            res_ready = ($urandom_range(0, 3) != 0);
            req_valid = pend;
            #1;
            checks++;
            if (res_valid !== m_vld ||
                (m_vld && (res !== m_res || res_carry !== m_c || res_id !== m_id))) begin
                errors++;
                $display("FAIL soak_result cyc=%0d valid=%b res=%h c=%b id=%0d exp valid=%b res=%h c=%b id=%0d",
                         cyc, res_valid, res, res_carry, res_id, m_vld, m_res, m_c, m_id);
            end
            exp_gnt = 4'h0;
            w = 0;
            if (!m_vld || res_ready) begin
                for (int i = 0; i < 4; i++) begin
                    kk = (m_ptr + i) % 4;
                    if (exp_gnt == 4'h0 && pend[kk]) begin
                        exp_gnt[kk] = 1'b1;
                        w = kk;
                    end
                end
            end
            checks++;
            if (req_ready !== exp_gnt) begin
                errors++;
                $display("FAIL soak_grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_gnt);
            end
            if (exp_gnt != 4'h0) begin
                r = ref_alu(sa[w], sb[w], so[w]);
                m_res = r[7:0]; m_c = r[8]; m_id = 2'(w); m_vld = 1'b1;
                m_ptr = (w + 1) % 4;
                pend[w] = 1'b0;
                grants++;
            end else if (res_ready) begin
                m_vld = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        req_valid = 4'h0;
        #1;
        checks++;
        if (grants != 1000) begin
            errors++;
            $display("FAIL soak_budget grants=%0d exp=1000", grants);
        end
`ifdef ALU_RR_SCHED_PERF_CNT_EN
        checks++;
        if (grant_cnt !== 32'(grants)) begin
            errors++;
            $display("FAIL soak_cnt got=%0d exp=%0d", grant_cnt, grants);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; req_a = '0; req_b = '0; req_op = '0;
        req_valid = '0; res_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_arith();
        test_backpressure();
        test_mid_reset();
        test_soak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
